mips_mem_arbiter: RTL
=====================

# mips_mem_arbiter

Arbitrates a single byte-wide memory shared by the MIPS instruction-fetch port and the load/store data port. Each granted request is a 32-bit word access, sequenced as four little-endian byte beats (byte at addr+0 maps to bits [7:0]). The block sits between the fetch/memory stages and the unified byte-addressable memory array. It replaces the separate instruction and data byte arrays once the core moves to a shared memory.

## Interface
- AW, 7: memory byte-address width (128 bytes)
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch byte address (pc)
- if_gnt  out  1  fetch granted; one-cycle pulse
- if_done  out  1  fetch word ready; one-cycle pulse
- if_rdata  out  32  fetched instruction word
- dm_req  in  1  data request; held until dm_done
- dm_we  in  1  1 = store word, 0 = load word
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_gnt  out  1  data granted; one-cycle pulse
- dm_done  out  1  data access complete; one-cycle pulse
- dm_rdata  out  32  load data
- mem_addr  out  AW  memory byte address
- mem_we  out  1  memory byte write enable
- mem_wdata  out  8  memory write byte
- mem_rdata  in  8  memory read byte; valid the cycle after mem_addr
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, XFER (beat counter 0..3), FIN, DONE.
- IDLE: if any req is high, the winner gets a combinational gnt pulse in the same cycle. The arbiter latches addr, we and wdata for the winner and moves to XFER with beat 0. If no req is high, it stays in IDLE.
- XFER beat k:
  - mem_addr = (addr + k) truncated to AW bits; addresses wrap modulo 2^AW.
  - No alignment check is made; addr[1:0] is used as given.
  - For a store: mem_we = 1 and mem_wdata = wdata[8k+7:8k].
  - For a load: mem_we = 0. Byte k-1, when k ≥ 1, is captured from mem_rdata into buffer[8(k-1)+7:8(k-1)].
  - Beat 3 moves to FIN.
- FIN: byte 3 is captured, mem_we = 0, and the state moves to DONE.
- DONE:
  - The winner's done pulses.
  - For a load, the winner's rdata register updates with the assembled word.
  - The fetch port is always a read; the fetch port never asserts mem_we.
  - The state moves to IDLE.
- Each rdata holds its value until that port's next completed load; stores leave dm_rdata unchanged.
- The loser's req stays pending and is arbitrated in the next IDLE cycle.
- Idle memory outputs: mem_addr = 0, mem_we = 0, mem_wdata = 0.

## Timing
- Reset: state IDLE, all outputs 0, if_rdata = dm_rdata = 0, priority pointer on fetch.
- Sequence: req sampled in cycle 0 (gnt), beats in cycles 1–4, FIN in cycle 5, done in cycle 6, IDLE in cycle 7.
- Fixed latency of 6 cycles from gnt to done for both loads and stores.
- Peak throughput is one word per 7 cycles.
- A requester must drop req in the cycle after done; a req still high in IDLE is a new request.
- Reset asserted mid-transaction: immediate return to IDLE and mem_we = 0. No done is issued and the rdata registers clear to 0.
- Both reqs rising in the same cycle: resolved by the arbitration policy.

## Configuration
- Macro `MEM_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - Under contention, the port not granted last wins.
  - After a grant to a port, the pointer moves to the other port.
  - An uncontended request always wins immediately.
- Undefined: fixed priority, data over fetch.
  - A continuously requesting data port starves fetch.
  - No pointer state exists.

## Test plan
- Memory bytes 0x10..0x13 preloaded with 0x11,0x22,0x33,0x44; fetch if_addr = 0x10 → if_gnt in cycle 0, mem_addr 0x10..0x13 in cycles 1–4, if_done in cycle 6, if_rdata = 0x44332211.
- Store dm_addr = 0x20, dm_wdata = 0xDEADBEEF → mem_we high in cycles 1–4 with bytes EF,BE,AD,DE at 0x20..0x23, then dm_done; a following load from 0x20 returns 0xDEADBEEF.
- Load dm_addr = 0x7E (AW = 7) → mem_addr sequence 0x7E, 0x7F, 0x00, 0x01.
- if_req and dm_req high together for 3 transactions:
  - without the macro → order D, D, D;
  - with MEM_ARB_RR_EN → order D, F, D.
- rst pulsed in cycle 3 of a store → mem_we drops asynchronously, no dm_done, state IDLE; a held req is re-granted after reset releases.

Source files
------------

// File: rtl/mips_mem_arbiter_if.sv
// Purpose: handshake and byte-memory bus bundle between the fetch/data requesters,
//          the mips_mem_arbiter and the shared byte-wide memory array.
// Ports:   slave modport = arbiter side (takes requests and mem_rdata, drives grants,
//          completions, read words and the byte bus); master modport = requester/memory side.
interface mips_mem_arbiter_if #(parameter int AW = 7);
    // fetch port
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_done;
    logic [31:0]   if_rdata;
    // load/store port
    logic          dm_req;
    logic          dm_we;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wdata;
    logic          dm_gnt;
    logic          dm_done;
    logic [31:0]   dm_rdata;
    // byte-wide memory
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Purpose: shares one byte-wide memory between MIPS fetch and load/store ports; each grant
//          is a 32-bit word moved as four little-endian byte beats.
// Latency: gnt (combinational, IDLE cycle) to done is a fixed 6 cycles; one word per 7 cycles.
// Backpressure: requesters hold req until done; the losing req simply waits in IDLE.
// Ports:   clk, rst (async, active-high), bus (mips_mem_arbiter_if.slave), busy (not IDLE).
// Config:  define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch.
module mips_mem_arbiter #(
    parameter int AW = 7
) (
    input  logic                clk,
    input  logic                rst,
    mips_mem_arbiter_if.slave   bus,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, XFER, FIN, DONE} state_t;

    state_t      state;
    logic [1:0]  beat;
    logic        owner_fetch;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [23:0] rbuf;        // bytes 0..2 of a load; byte 3 joins straight from mem_rdata

    logic        fetch_wins;
    logic        data_wins;
    logic        any_grant;
    logic [31:0] sel_addr;
    logic        sel_store;
    logic [31:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
    // Pointer holds the last granted port; reset value "fetch" lets data win first.
    logic last_data;

    always_comb fetch_wins = bus.if_req && (!bus.dm_req || last_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_data <= 1'b0;
        else if (state == IDLE && any_grant)
            last_data <= data_wins;
    end
`else
    always_comb fetch_wins = bus.if_req && !bus.dm_req;
`endif

    assign data_wins = bus.dm_req && !fetch_wins;
    assign any_grant = fetch_wins || data_wins;

    assign sel_addr  = fetch_wins ? bus.if_addr : bus.dm_addr;
    assign sel_store = data_wins && bus.dm_we;       // fetch is always a read
    assign sel_wdata = sel_store ? bus.dm_wdata : 32'd0;

    // Grants are combinational but masked during reset so every output reads 0 there.
    assign bus.if_gnt = !rst && (state == IDLE) && fetch_wins;
    assign bus.dm_gnt = !rst && (state == IDLE) && data_wins;
    assign busy       = (state != IDLE);

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    byte_sel = w[7:0];
            2'd1:    byte_sel = w[15:8];
            2'd2:    byte_sel = w[23:16];
            default: byte_sel = w[31:24];
        endcase
    endfunction

    // Memory outputs are registered one step ahead: the value for beat k is loaded on the
    // edge that enters beat k, so the memory sees it for exactly that beat's cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            beat          <= 2'd0;
            owner_fetch   <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            rbuf          <= 24'd0;
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= 8'd0;
            bus.if_done   <= 1'b0;
            bus.dm_done   <= 1'b0;
            bus.if_rdata  <= 32'd0;
            bus.dm_rdata  <= 32'd0;
        end else begin
            bus.if_done <= 1'b0;
            bus.dm_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_grant) begin
                        owner_fetch   <= fetch_wins;
                        we_q          <= sel_store;
                        addr_q        <= sel_addr;
                        wdata_q       <= sel_wdata;
                        beat          <= 2'd0;
                        state         <= XFER;
                        bus.mem_addr  <= AW'(sel_addr);
                        bus.mem_we    <= sel_store;
                        bus.mem_wdata <= byte_sel(sel_wdata, 2'd0);
                    end
                end
                XFER: begin
                    // mem_rdata now carries the byte addressed during the previous beat.
                    case (beat)
                        2'd1:    rbuf[7:0]   <= bus.mem_rdata;
                        2'd2:    rbuf[15:8]  <= bus.mem_rdata;
                        2'd3:    rbuf[23:16] <= bus.mem_rdata;
                        default: ;
                    endcase
                    if (beat == 2'd3) begin
                        state         <= FIN;
                        bus.mem_addr  <= '0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_wdata <= 8'd0;
                    end else begin
                        beat          <= beat + 2'd1;
                        // Full-width add then truncate: addresses wrap modulo 2^AW.
                        bus.mem_addr  <= AW'(addr_q + {30'd0, beat + 2'd1});
                        bus.mem_wdata <= byte_sel(wdata_q, beat + 2'd1);
                    end
                end
                FIN: begin
                    // Done and the assembled word land together, visible in the DONE cycle.
                    state <= DONE;
                    if (owner_fetch) begin
                        bus.if_done  <= 1'b1;
                        bus.if_rdata <= {bus.mem_rdata, rbuf};
                    end else begin
                        bus.dm_done <= 1'b1;
                        if (!we_q)
                            bus.dm_rdata <= {bus.mem_rdata, rbuf};
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
